// File: rtl/branch_queue_pkg.sv
// Shared types for the branch queue: ALU resolve bus, queue entry layout, depth/id widths.
package branch_queue_pkg;

  localparam int BQ_DEPTH = 8;
  localparam int BQ_ID_W  = $clog2(BQ_DEPTH);
  localparam int BQ_CNT_W = BQ_ID_W + 1;

  typedef logic [BQ_ID_W-1:0]  bq_id_t;
  typedef logic [BQ_CNT_W-1:0] bq_cnt_t;

  typedef struct packed {
    logic        ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    bq_id_t      bq_id;
  } bq_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolved;
    logic        taken;
    logic [31:0] target;
  } bq_entry_t;

  // A taken branch that went somewhere other than the predicted target is also a mispredict.
  function automatic logic bq_mispredict(input bq_entry_t e);
    return (e.taken != e.pred_taken) || (e.taken && (e.target != e.pred_target));
  endfunction

  function automatic logic [31:0] bq_actual_pc(input bq_entry_t e);
    return e.taken ? e.target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_queue_if.sv
// Dispatch / branch-ALU / ROB-facing signals of the branch queue; master = core side, slave = queue.
interface branch_queue_if;
  import branch_queue_pkg::*;

  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_pred_taken;
  logic [31:0] alloc_pred_target;
  logic        alloc_ready;
  bq_id_t      alloc_bq_id;
  bq_bus_t     bq_bus;
  logic        head_valid;
  logic        head_resolved;
  logic        commit;
  logic        flush_valid;
  logic [31:0] flush_pc;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, bq_bus, commit,
    input  alloc_ready, alloc_bq_id, head_valid, head_resolved, flush_valid, flush_pc
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, bq_bus, commit,
    output alloc_ready, alloc_bq_id, head_valid, head_resolved, flush_valid, flush_pc
  );

endinterface

// File: rtl/branch_queue.sv
// In-order branch queue: alloc at dispatch, out-of-order resolve, in-order commit with
// mispredict detection that empties the queue and issues a registered one-cycle flush/redirect.
module branch_queue
  import branch_queue_pkg::*;
(
  input logic           clk,
  input logic           rst,
  branch_queue_if.slave bq
);

  localparam bq_cnt_t FULL_CNT = BQ_CNT_W'(BQ_DEPTH);

  bq_entry_t   r_entries [BQ_DEPTH];
  bq_id_t      r_head;
  bq_id_t      r_tail;
  bq_cnt_t     r_count;
  logic        r_flush_vld;
  logic [31:0] r_flush_pc;

  bq_entry_t   w_head_entry;
  logic        w_full;
  logic        w_alloc_fire;
  logic        w_resolve_fire;
  logic        w_head_resolved;
  logic        w_commit_fire;
  logic        w_do_flush;
  logic [31:0] w_actual_pc;

  assign w_head_entry    = r_entries[r_head];
  assign w_full          = (r_count == FULL_CNT);
  assign w_alloc_fire    = bq.alloc_valid && !w_full;
  assign w_resolve_fire  = bq.bq_bus.ready && r_entries[bq.bq_bus.bq_id].valid;
  assign w_head_resolved = w_head_entry.valid && w_head_entry.resolved;
  assign w_commit_fire   = bq.commit && w_head_resolved;
  assign w_do_flush      = w_commit_fire && bq_mispredict(w_head_entry);
  assign w_actual_pc     = bq_actual_pc(w_head_entry);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BQ_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_flush_vld <= 1'b0;
      r_flush_pc  <= '0;
    end else if (w_do_flush) begin
      // Everything younger than the mispredicted branch is wrong-path, including this cycle's alloc/resolve.
      for (int i = 0; i < BQ_DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_flush_vld <= 1'b1;
      r_flush_pc  <= w_actual_pc;
    end else begin
      r_flush_vld <= 1'b0;

      if (w_resolve_fire) begin
        r_entries[bq.bq_bus.bq_id].resolved <= 1'b1;
        r_entries[bq.bq_bus.bq_id].taken    <= bq.bq_bus.branch_taken;
        r_entries[bq.bq_bus.bq_id].target   <= bq.bq_bus.branch_target;
      end

      if (w_commit_fire) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end

      // The tail slot is never valid when alloc fires, so it cannot collide with resolve or commit.
      if (w_alloc_fire) begin
        r_entries[r_tail] <= '{valid:       1'b1,
                               pc:          bq.alloc_pc,
                               pred_taken:  bq.alloc_pred_taken,
                               pred_target: bq.alloc_pred_target,
                               resolved:    1'b0,
                               taken:       1'b0,
                               target:      32'd0};
        r_tail <= r_tail + 1'b1;
      end

      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bq.alloc_ready   = !w_full;
  assign bq.alloc_bq_id   = r_tail;
  assign bq.head_valid    = w_head_entry.valid;
  assign bq.head_resolved = w_head_resolved;
  assign bq.flush_valid   = r_flush_vld;
  assign bq.flush_pc      = r_flush_pc;

  commit_needs_resolved_head: assert property (@(posedge clk) disable iff (rst)
    bq.commit |-> w_head_resolved);

endmodule

// File: tb/tb_branch_queue.sv
// Directed + randomized bench for branch_queue against a queue-of-records reference model.
module tb_branch_queue;
  import branch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_queue_if bq_if ();
  branch_queue dut (.clk(clk), .rst(rst), .bq(bq_if));

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        res;
    logic        tk;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_next;
  logic        m_fv;
  logic [31:0] m_fpc;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next = 0;
    m_fv   = 1'b0;
    m_fpc  = 32'd0;
  endtask

  // Applies one clock edge of the rules to the model, reading the inputs currently on the interface.
  task automatic model_step();
    bit          full, hres, misp, do_commit;
    m_ent_t      e, n;
    logic [31:0] act;
    if (rst) begin
      model_reset();
      return;
    end
    full      = (mq.size() == BQ_DEPTH);
    hres      = (mq.size() != 0) && mq[0].res;
    do_commit = bq_if.commit && hres;
    if (do_commit) begin
      e    = mq[0];
      act  = e.tk ? e.tgt : e.pc + 32'd4;
      misp = (e.tk != e.pt) || (e.tk && (e.tgt != e.ptgt));
      if (misp) begin
        mq.delete();
        m_next = 0;
        m_fv   = 1'b1;
        m_fpc  = act;
        return;
      end
    end
    m_fv = 1'b0;
    if (bq_if.bq_bus.ready) begin
      foreach (mq[i]) begin
        if (mq[i].id == int'(bq_if.bq_bus.bq_id)) begin
          mq[i].res = 1'b1;
          mq[i].tk  = bq_if.bq_bus.branch_taken;
          mq[i].tgt = bq_if.bq_bus.branch_target;
        end
      end
    end
    if (do_commit) void'(mq.pop_front());
    if (bq_if.alloc_valid && !full) begin
      n = '{id: m_next, pc: bq_if.alloc_pc, pt: bq_if.alloc_pred_taken,
            ptgt: bq_if.alloc_pred_target, res: 1'b0, tk: 1'b0, tgt: 32'd0};
      mq.push_back(n);
      m_next = (m_next + 1) % BQ_DEPTH;
    end
  endtask

  task automatic check_all();
    logic hv;
    hv = (mq.size() != 0);
    chk("alloc_ready", 32'(bq_if.alloc_ready), 32'(mq.size() != BQ_DEPTH));
    chk("alloc_bq_id", 32'(bq_if.alloc_bq_id), 32'(m_next));
    chk("head_valid", 32'(bq_if.head_valid), 32'(hv));
    chk("head_resolved", 32'(bq_if.head_resolved), 32'(hv && mq[0].res));
    chk("flush_valid", 32'(bq_if.flush_valid), 32'(m_fv));
    if (m_fv) chk("flush_pc", bq_if.flush_pc, m_fpc);
  endtask

  task automatic set_idle();
    bq_if.alloc_valid       = 1'b0;
    bq_if.alloc_pc          = 32'd0;
    bq_if.alloc_pred_taken  = 1'b0;
    bq_if.alloc_pred_target = 32'd0;
    bq_if.bq_bus            = '0;
    bq_if.commit            = 1'b0;
  endtask

  task automatic cyc(input logic av, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                     input logic rv, input bq_id_t rid, input logic rt, input logic [31:0] rtgt,
                     input logic cm);
    bq_if.alloc_valid          = av;
    bq_if.alloc_pc             = pc;
    bq_if.alloc_pred_taken     = pt;
    bq_if.alloc_pred_target    = ptgt;
    bq_if.bq_bus.ready         = rv;
    bq_if.bq_bus.bq_id         = rid;
    bq_if.bq_bus.branch_taken  = rt;
    bq_if.bq_bus.branch_target = rtgt;
    bq_if.commit               = cm;
    @(posedge clk);
    model_step();
    #1;
    set_idle();
    check_all();
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    cyc(1'b1, pc, pt, ptgt, 1'b0, '0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resolve(input bq_id_t id, input logic tk, input logic [31:0] tgt);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, id, tk, tgt, 1'b0);
  endtask

  task automatic do_commit();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    chk("rst_alloc_ready", 32'(bq_if.alloc_ready), 32'd1);
    chk("rst_head_valid", 32'(bq_if.head_valid), 32'd0);
    chk("rst_head_resolved", 32'(bq_if.head_resolved), 32'd0);
    chk("rst_flush_valid", 32'(bq_if.flush_valid), 32'd0);
    chk("rst_bq_id", 32'(bq_if.alloc_bq_id), 32'd0);
  endtask

  initial begin
    logic        av, pt, rv, rt, cm;
    logic [31:0] pc, ptgt, rtgt;
    bq_id_t      rid;
    n_checks = 0;
    n_errors = 0;
    set_idle();
    model_reset();
    @(posedge clk);
    do_reset();
    chk("rst_flush_pc", bq_if.flush_pc, 32'd0);

    // Fill to full; the ninth request must be ignored.
    for (int i = 0; i < BQ_DEPTH; i++) begin
      chk("fill_id", 32'(bq_if.alloc_bq_id), 32'(i));
      alloc(32'h4000 + 32'(i * 4), 1'b0, 32'd0);
    end
    chk("full_ready", 32'(bq_if.alloc_ready), 32'd0);
    alloc(32'h5000, 1'b0, 32'd0);
    chk("full_ignored_ready", 32'(bq_if.alloc_ready), 32'd0);
    chk("full_ignored_id", 32'(bq_if.alloc_bq_id), 32'd0);
    do_reset();

    // Out-of-order resolve, in-order commit.
    for (int i = 0; i < 3; i++) alloc(32'h600 + 32'(i * 4), 1'b0, 32'd0);
    resolve(2, 1'b0, 32'd0);
    resolve(1, 1'b0, 32'd0);
    chk("ooo_head_unres", 32'(bq_if.head_resolved), 32'd0);
    resolve(0, 1'b0, 32'd0);
    chk("ooo_head_res", 32'(bq_if.head_resolved), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_commit();
      chk("ooo_no_flush", 32'(bq_if.flush_valid), 32'd0);
    end
    chk("ooo_empty", 32'(bq_if.head_valid), 32'd0);

    // Correct prediction.
    alloc(32'h100, 1'b0, 32'd0);
    resolve(3, 1'b0, 32'd0);
    do_commit();
    chk("correct_no_flush", 32'(bq_if.flush_valid), 32'd0);

    // Direction mispredict with a same-cycle alloc that must be dropped.
    alloc(32'h200, 1'b1, 32'h240);
    resolve(4, 1'b0, 32'd0);
    cyc(1'b1, 32'h900, 1'b0, 32'd0, 1'b0, '0, 1'b0, 32'd0, 1'b1);
    chk("misp_flush_valid", 32'(bq_if.flush_valid), 32'd1);
    chk("misp_flush_pc", bq_if.flush_pc, 32'h204);
    chk("misp_head_valid", 32'(bq_if.head_valid), 32'd0);
    chk("misp_bq_id", 32'(bq_if.alloc_bq_id), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 32'd0, 1'b0);
    chk("misp_flush_drop", 32'(bq_if.flush_valid), 32'd0);

    // Target mispredict.
    alloc(32'h300, 1'b1, 32'h240);
    resolve(0, 1'b1, 32'h280);
    do_commit();
    chk("tgt_flush_valid", 32'(bq_if.flush_valid), 32'd1);
    chk("tgt_flush_pc", bq_if.flush_pc, 32'h280);

    // Id wrap across twelve rounds.
    for (int r = 0; r < 12; r++) begin
      chk("wrap_id", 32'(bq_if.alloc_bq_id), 32'(r % BQ_DEPTH));
      alloc(32'h1000 + 32'(r * 4), 1'b0, 32'd0);
      resolve(bq_id_t'(r % BQ_DEPTH), 1'b0, 32'd0);
      do_commit();
    end

    // Reset with live entries.
    for (int i = 0; i < 5; i++) alloc(32'h2000 + 32'(i * 4), 1'b0, 32'd0);
    chk("pre_rst_head_valid", 32'(bq_if.head_valid), 32'd1);
    do_reset();

    // Randomized traffic, biased towards correct predictions to keep the queue populated.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      av   = ($urandom_range(0, 2) != 0);
      pc   = {$urandom_range(0, 32'hFFFF), 2'b00};
      pt   = $urandom_range(0, 1);
      ptgt = {$urandom_range(0, 32'hFFFF), 2'b00};
      rv   = ($urandom_range(0, 9) < 7);
      rid  = bq_id_t'($urandom_range(0, BQ_DEPTH - 1));
      rt   = pt;
      rtgt = ptgt;
      if (mq.size() != 0 && $urandom_range(0, 4) != 0) begin
        int k;
        k    = $urandom_range(0, mq.size() - 1);
        rid  = bq_id_t'(mq[k].id);
        rt   = ($urandom_range(0, 19) == 0) ? !mq[k].pt : mq[k].pt;
        rtgt = ($urandom_range(0, 19) == 0) ? 32'(c) + 32'h8000_0000 : mq[k].ptgt;
      end
      cm = (mq.size() != 0) && mq[0].res && ($urandom_range(0, 9) < 6);
      cyc(av, pc, pt, ptgt, rv, rid, rt, rtgt, cm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
